// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity encodings,
// default bit timing and the transmit FSM state type.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 10 MHz / 9600 baud, truncated
  localparam int DEFAULT_CLKS_PER_BIT = 1041;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy
// count. Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8-bit UART transmitter: bytes enter a FIFO over valid/ready and
// leave LSB-first as start, data, optional parity and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          uart_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic              ODD_PAR  = (PARITY == PARITY_ODD);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic             tx_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic             bit_done;
  logic             last_stop;
  logic             pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .push    (valid_i),
    .wr_data (data_i),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  assign bit_done  = (bit_cnt == CNT_LAST);
  assign last_stop = (state == ST_STOP) && bit_done && (STOP_BITS == 1 || stop_idx);
  // Popping on the final stop cycle is what makes back-to-back frames gapless
  assign pop       = !fifo_empty && (state == ST_IDLE || last_stop);

  assign ready_o   = !fifo_full;
  assign busy_o    = (state != ST_IDLE) || !fifo_empty;
  assign uart_tx_o = tx_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      tx_reg     <= 1'b1;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      bit_cnt <= (state == ST_IDLE || bit_done) ? '0 : bit_cnt + CNT_W'(1);
      if (pop) begin
        state      <= ST_START;
        tx_reg     <= 1'b0;
        shift_reg  <= fifo_data;
        parity_bit <= (^fifo_data) ^ ODD_PAR;
      end else if (bit_done) begin
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            tx_reg  <= shift_reg[0];
            bit_idx <= '0;
          end
          ST_DATA: begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                state  <= ST_PARITY;
                tx_reg <= parity_bit;
              end else begin
                state    <= ST_STOP;
                tx_reg   <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              tx_reg    <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
          ST_PARITY: begin
            state    <= ST_STOP;
            tx_reg   <= 1'b1;
            stop_idx <= 1'b0;
          end
          ST_STOP: begin
            if (STOP_BITS == 1 || stop_idx) begin
              state  <= ST_IDLE;
              tx_reg <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8-bit UART transmitter for the GateMate UART designs. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first as start, data, optional parity and stop bits on a single TX line. Used on the transmit side of the UART loop design, fed from the receive path or from user logic.

## Interface
- `CLKS_PER_BIT`, 1041: clock cycles per UART bit, i.e. 10 MHz / 9600 baud truncated; legal values ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: number of FIFO entries; power of two, ≥ 2.

- `clk_i` input 1: single design clock; all logic is on the rising edge.
- `rst_n_i` input 1: reset, synchronous and active-low.
- `data_i` input 8: byte to send.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: FIFO can accept a byte; equals not-full.
- `uart_tx_o` output 1: serial line, idle high.
- `busy_o` output 1: a frame is in progress or the FIFO is non-empty.
- `level_o` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Reset values: `uart_tx_o` = 1, `ready_o` = 1, `busy_o` = 0, `level_o` = 0. Reset empties the FIFO and puts the FSM in IDLE.
- Push: when `valid_i` and `ready_o` are both high on a rising edge, `data_i` is written to the FIFO. `ready_o` is low when the FIFO is full. When `ready_o` is low, `valid_i` is ignored and no data is lost or overwritten.
- Pop: only in IDLE, or in the last cycle of the last stop bit, and only when the FIFO is non-empty. The popped byte loads the shift register and the FSM enters START.
- Same-edge push and pop on a non-full FIFO: both take effect and `level_o` is unchanged.
- FSM states:
  - IDLE: line high.
  - START: line 0 for one bit time.
  - DATA: 8 bits, LSB first.
  - PARITY: only when `PARITY` ≠ 0; even = XOR of the data bits, odd = its inverse.
  - STOP: line 1 for `STOP_BITS` bit times.
  - STOP exit: goes to START if the FIFO is non-empty, otherwise to IDLE.
- Counters:
  - Bit-time counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and advances the state or bit index at terminal count.
  - Bit index is 3 bits and wraps after bit 7 into PARITY or STOP.
- `uart_tx_o` is driven from a register, so it never glitches.
- Reset mid-frame: on the next edge the line returns to 1, the FSM goes to IDLE, and the FIFO is cleared. A partial frame is aborted and never resumed.

## Timing
- Latency: a byte accepted at edge k while the FSM is idle and the FIFO is empty drives `uart_tx_o` low from edge k+1.
- Frame length is exactly (1 + 8 + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 if parity is enabled, else 0.
- Back-to-back frames: no idle cycles between a stop bit and the next start bit while the FIFO is non-empty.
- `ready_o` reasserts on the edge after a pop from a full FIFO.
- `busy_o` rises on the edge of the first push.
- `busy_o` falls on the edge that ends the final stop bit with the FIFO empty.

## Structure
- Package `uart_pkg`:
  - parity encoding constants;
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - default `CLKS_PER_BIT` for 10 MHz / 9600.
- Sub-module `sync_fifo`, parameterised by width and depth:
  - ports: push, pop, full, empty, level;
  - first-word data visible combinationally when non-empty.
- `uart_tx` contains the FSM, counters, parity and shift register.

## Test plan
- Reset: drive `rst_n_i` low for 2 cycles, then check `uart_tx_o` = 1, `ready_o` = 1, `busy_o` = 0, `level_o` = 0, and the line stays high for 20000 cycles.
- Single byte 0x55 with defaults, pushed at edge k: the line is low from k+1 for 1041 cycles, then bits 1,0,1,0,1,0,1,0 at 1041 cycles each, then high. `busy_o` falls at k+1+10410.
- Burst: push 0x01..0x06 on consecutive cycles with `FIFO_DEPTH` = 4.
  - 0x01..0x05 are accepted; `ready_o` goes low after the 5th byte and 0x06 stalls until the first frame ends.
  - The six frames are emitted in order with no gaps: 6 × 10410 cycles total.
- Parity and stop bits with `PARITY` = 2, `STOP_BITS` = 2:
  - byte 0x00 gives parity bit 1 and a 12-bit frame;
  - with `PARITY` = 1, byte 0x07 gives parity bit 1.
- Reset mid-frame: assert reset during data bit 3 of 0xA5 with 2 more bytes queued. Required: the line is high on the next edge, `level_o` = 0, and no further frames follow.
- Loopback: 16 random bytes go through a bench receiver that samples at 1.5 bit times after each falling edge and then every bit time. Every byte must match, in order.
